puf_ascon_config_sequencer: RTL and testbench

- Parametrised successor to the team's single-shot PUF-keyed config encryptor.
- Folds a configurable-width PUF response stream into a 128-bit ASCON key.
- Encrypts NUM_BLK 128-bit test-config blocks in sequence, each with a unique counter nonce, through an external ascon128_encrypt core, using a start/done handshake.
- Streams ciphertext and tag out over valid/ready, with a watchdog timeout, an abort input, and key zeroization.

---
 rtl/puf_ascon_cfg_pkg.sv | 28 ++
 rtl/puf_ascon_config_sequencer_if.sv | 36 +++
 rtl/puf_key_folder.sv | 39 +++
 rtl/puf_ascon_config_sequencer.sv | 131 +++++++++++++
 tb/tb_puf_ascon_config_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_ascon_cfg_pkg.sv
// Shared types and helpers for the PUF-keyed ASCON config sequencer.
// Holds the FSM state encoding, the key/block widths and the key-fold rotate.
package puf_ascon_cfg_pkg;

  localparam int KEY_W = 128;
  localparam int BLK_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    LOAD,
    ENC,
    WAIT,
    OUT,
    FIN,
    ERR
  } state_e;

  // Number of PUF words needed to fill a full key.
  function automatic int key_words(input int puf_w);
    return (KEY_W + puf_w - 1) / puf_w;
  endfunction

  function automatic logic [KEY_W-1:0] rotl(input logic [KEY_W-1:0] x, input int unsigned n);
    return (x << n) | (x >> (KEY_W - n));
  endfunction

endpackage

// File: rtl/puf_ascon_config_sequencer_if.sv
// Encrypt-core handshake and ciphertext output stream of the config sequencer.
// master = sequencer side, slave = encrypt core plus downstream consumer.
interface puf_ascon_config_sequencer_if #(
  parameter int IDX_W = 2
);
  import puf_ascon_cfg_pkg::*;

  logic [KEY_W-1:0] enc_key;
  logic [BLK_W-1:0] enc_nonce;
  logic [BLK_W-1:0] enc_plain;
  logic             enc_start;
  logic             enc_done;
  logic [BLK_W-1:0] enc_ct;
  logic [BLK_W-1:0] enc_tag;

  logic [BLK_W-1:0] out_ct;
  logic [BLK_W-1:0] out_tag;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output enc_key, enc_nonce, enc_plain, enc_start,
    input  enc_done, enc_ct, enc_tag,
    output out_ct, out_tag, out_idx, out_valid,
    input  out_ready
  );

  modport slave (
    input  enc_key, enc_nonce, enc_plain, enc_start,
    output enc_done, enc_ct, enc_tag,
    input  out_ct, out_tag, out_idx, out_valid,
    output out_ready
  );

endinterface

// File: rtl/puf_key_folder.sv
// Folds a stream of PUF words into a 128-bit key by rotate-and-XOR.
// key_full_o flags the fold that completes the key, so the caller can move on that same cycle.
module puf_key_folder
  import puf_ascon_cfg_pkg::*;
#(
  parameter int PUF_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             fold_i,
  input  logic [PUF_W-1:0] word_i,
  output logic [KEY_W-1:0] key_o,
  output logic             key_full_o
);

  localparam int KEY_WORDS = key_words(PUF_W);
  localparam int CNT_W     = $clog2(KEY_WORDS + 1);

  logic [KEY_W-1:0] key_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      key_q <= '0;
      cnt_q <= '0;
    end else if (fold_i) begin
      key_q <= rotl(key_q, PUF_W) ^ KEY_W'(word_i);
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign key_o      = key_q;
  assign key_full_o = fold_i && (cnt_q == CNT_W'(KEY_WORDS - 1));

endmodule

// File: rtl/puf_ascon_config_sequencer.sv
// Builds an ASCON key from the PUF, then encrypts NUM_BLK config blocks through an
// external core with per-block counter nonces and streams ciphertext/tag out.
module puf_ascon_config_sequencer
  import puf_ascon_cfg_pkg::*;
#(
  parameter int           PUF_W      = 16,
  parameter int           NUM_BLK    = 4,
  parameter logic [127:0] NONCE_BASE = 128'h0,
  parameter int           TIMEOUT    = 1024,
  localparam int          IDX_W      = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PUF_W-1:0] puf_response,
  input  logic             puf_valid,
  input  logic [BLK_W-1:0] cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  puf_ascon_config_sequencer_if.master bus
);

  localparam int TMR_W = $clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [TMR_W-1:0] timer_q;
  logic [KEY_W-1:0] key, enc_key_q;
  logic [BLK_W-1:0] enc_nonce_q, enc_plain_q, out_ct_q, out_tag_q;
  logic             key_full, fold, zeroize;
  logic             busy_q, done_q, error_q, cfg_ready_q, enc_start_q, out_valid_q;
  logic             enc_active_d;

  assign fold    = (state_q == KEY) && puf_valid && !abort;
  assign zeroize = state_d inside {IDLE, FIN, ERR};

  puf_key_folder #(.PUF_W(PUF_W)) u_fold (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (zeroize),
    .fold_i     (fold),
    .word_i     (puf_response),
    .key_o      (key),
    .key_full_o (key_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = KEY;
      KEY:     if (key_full) state_d = LOAD;
      LOAD:    if (cfg_valid) state_d = ENC;
      ENC:     state_d = WAIT;
      WAIT: begin
        if (bus.enc_done) state_d = OUT;
        else if (timer_q == TMR_W'(TIMEOUT - 1)) state_d = ERR;
      end
      OUT:     if (bus.out_ready) state_d = (idx_q == IDX_W'(NUM_BLK - 1)) ? FIN : LOAD;
      FIN:     state_d = IDLE;
      ERR:     if (start) state_d = KEY;
      default: state_d = IDLE;
    endcase
    // Abort overrides every other event in the active states.
    if (abort && (state_q inside {KEY, LOAD, ENC, WAIT, OUT})) state_d = IDLE;
  end

  assign enc_active_d = state_d inside {ENC, WAIT};

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
      enc_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      enc_key_q   <= '0;
      enc_nonce_q <= '0;
      enc_plain_q <= '0;
      out_ct_q    <= '0;
      out_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= state_d inside {KEY, LOAD, ENC, WAIT, OUT, FIN};
      done_q      <= (state_d == FIN);
      error_q     <= (state_d == ERR);
      cfg_ready_q <= (state_d == LOAD);
      enc_start_q <= (state_d == ENC);
      out_valid_q <= (state_d == OUT);

      if (state_q inside {IDLE, ERR}) idx_q <= '0;
      else if ((state_q == OUT) && (state_d == LOAD)) idx_q <= idx_q + 1'b1;

      // Timer reads 0 in ENC, so it equals cycles elapsed since enc_start.
      if (state_d == ENC) timer_q <= '0;
      else if (state_q inside {ENC, WAIT}) timer_q <= timer_q + 1'b1;

      enc_key_q   <= enc_active_d ? key : '0;
      enc_nonce_q <= enc_active_d ? (NONCE_BASE + KEY_W'(idx_q)) : '0;
      if ((state_q == LOAD) && (state_d == ENC)) enc_plain_q <= cfg_data;
      else if (!enc_active_d) enc_plain_q <= '0;

      if ((state_q == WAIT) && (state_d == OUT)) begin
        out_ct_q  <= bus.enc_ct;
        out_tag_q <= bus.enc_tag;
      end
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign bus.enc_key   = enc_key_q;
  assign bus.enc_nonce = enc_nonce_q;
  assign bus.enc_plain = enc_plain_q;
  assign bus.enc_start = enc_start_q;
  assign bus.out_ct    = out_ct_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_puf_ascon_config_sequencer.sv
// Bench for puf_ascon_config_sequencer: a 16-bit/4-block instance with a behavioural
// encrypt core, and a 24-bit/2-block instance for odd-width folding and async reset.
module tb_puf_ascon_config_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, rst_nb;
  logic         start_a, abort_a, puf_valid_a, cfg_valid_a, cfg_ready_a, busy_a, done_a, error_a;
  logic [15:0]  puf_a;
  logic [127:0] cfg_data_a;
  logic         start_b, abort_b, puf_valid_b, cfg_valid_b, cfg_ready_b, busy_b, done_b, error_b;
  logic [23:0]  puf_b;
  logic [127:0] cfg_data_b;

  puf_ascon_config_sequencer_if #(.IDX_W(2)) ifa ();
  puf_ascon_config_sequencer_if #(.IDX_W(1)) ifb ();

  puf_ascon_config_sequencer #(
    .PUF_W(16), .NUM_BLK(4), .NONCE_BASE(128'h10), .TIMEOUT(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .puf_response(puf_a), .puf_valid(puf_valid_a),
    .cfg_data(cfg_data_a), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
    .busy(busy_a), .done(done_a), .error(error_a), .bus(ifa)
  );

  puf_ascon_config_sequencer #(
    .PUF_W(24), .NUM_BLK(2), .NONCE_BASE(128'h0), .TIMEOUT(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_nb), .start(start_b), .abort(abort_b),
    .puf_response(puf_b), .puf_valid(puf_valid_b),
    .cfg_data(cfg_data_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
    .busy(busy_b), .done(done_b), .error(error_b), .bus(ifb)
  );

  typedef struct {
    logic [127:0] plain;
    int           lat;
    int           bp;
    logic [127:0] exp_nonce;
    int           exp_idx;
  } vec_t;

  vec_t         vt[4];
  logic [127:0] words[8];
  int           checks = 0, failures = 0;
  int           core_lat = 0;
  int           done_cnt = 0, ov_cnt = 0, st_cnt = 0;
  bit           gaps = 1'b0;
  logic [127:0] core_k, core_n, core_p;

  // Reference key: word j ends up rotated left by width*(n-1-j), all words XORed.
  function automatic logic [127:0] rot_ref(input logic [127:0] x, input int r);
    logic [127:0] y;
    for (int b = 0; b < 128; b++) y[(b + r) % 128] = x[b];
    return y;
  endfunction

  function automatic logic [127:0] fold_ref(input int n, input int width);
    logic [127:0] k = '0;
    for (int j = 0; j < n; j++) k ^= rot_ref(words[j], (width * (n - 1 - j)) % 128);
    return k;
  endfunction

  function automatic logic [127:0] core_ct(input logic [127:0] k, input logic [127:0] n,
                                           input logic [127:0] p);
    return p ^ k ^ {n[63:0], n[127:64]};
  endfunction

  function automatic logic [127:0] core_tag(input logic [127:0] k, input logic [127:0] n,
                                            input logic [127:0] p);
    return k + n + p + 128'h5a;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encrypt core model: responds core_lat-1 cycles after seeing enc_start (0 = never).
  initial begin
    ifa.enc_done = 1'b0;
    ifa.enc_ct   = '0;
    ifa.enc_tag  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ifa.enc_start && core_lat > 1) begin
        core_k = ifa.enc_key;
        core_n = ifa.enc_nonce;
        core_p = ifa.enc_plain;
        repeat (core_lat - 1) @(posedge clk);
        #1;
        ifa.enc_ct   = core_ct(core_k, core_n, core_p);
        ifa.enc_tag  = core_tag(core_k, core_n, core_p);
        ifa.enc_done = 1'b1;
        @(posedge clk);
        #1;
        ifa.enc_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done_a) done_cnt++;
      if (ifa.out_valid) ov_cnt++;
      if (ifa.enc_start) st_cnt++;
    end
  end

  initial begin
    ifb.enc_done = 1'b0;
    ifb.enc_ct   = '0;
    ifb.enc_tag  = '0;
    ifb.out_ready = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_a_pulse();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic feed_a(input int n);
    for (int j = 0; j < n; j++) begin
      puf_a = words[j][15:0];
      puf_valid_a = 1'b1;
      tick();
      if (gaps) begin
        puf_valid_a = 1'b0;
        puf_a = 16'($urandom);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    puf_valid_a = 1'b0;
  endtask

  task automatic run_a(input logic [127:0] key_exp);
    int n, d0, s0;
    logic [127:0] ect, etag;
    d0 = done_cnt;
    start_a_pulse();
    chk1("busy_after_start", busy_a, 1'b1);
    feed_a(8);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!cfg_ready_a && n < 100) begin tick(); n++; end
      chk1("cfg_ready", cfg_ready_a, 1'b1);
      core_lat = vt[i].lat;
      cfg_data_a = vt[i].plain;
      cfg_valid_a = 1'b1;
      tick();
      cfg_valid_a = 1'b0;
      chk1("enc_start", ifa.enc_start, 1'b1);
      chk("enc_key", ifa.enc_key, key_exp);
      chk("enc_nonce", ifa.enc_nonce, vt[i].exp_nonce);
      chk("enc_plain", ifa.enc_plain, vt[i].plain);
      n = 0;
      while (!ifa.out_valid && n < 100) begin tick(); n++; end
      ect  = core_ct(key_exp, vt[i].exp_nonce, vt[i].plain);
      etag = core_tag(key_exp, vt[i].exp_nonce, vt[i].plain);
      chk1("out_valid", ifa.out_valid, 1'b1);
      chk("out_ct", ifa.out_ct, ect);
      chk("out_tag", ifa.out_tag, etag);
      chk("out_idx", 128'(ifa.out_idx), 128'(vt[i].exp_idx));
      s0 = st_cnt;
      repeat (vt[i].bp) begin
        tick();
        chk("bp_ct", ifa.out_ct ^ ifa.out_tag, ect ^ etag);
        chk("bp_idx", 128'(ifa.out_idx), 128'(vt[i].exp_idx));
        chk("bp_ctrl", 128'({ifa.out_valid, cfg_ready_a, ifa.enc_start}), 128'(3'b100));
      end
      if (vt[i].bp > 0) chk("bp_no_restart", 128'(st_cnt), 128'(s0));
      ifa.out_ready = 1'b1;
      tick();
      ifa.out_ready = 1'b0;
    end
    chk1("done_pulse", done_a, 1'b1);
    chk("key_zero_fin", dut_a.u_fold.key_o, '0);
    tick();
    chk1("done_low", done_a, 1'b0);
    chk1("busy_low", busy_a, 1'b0);
    tick();
    chk("done_once", 128'(done_cnt - d0), 128'(1));
  endtask

  initial begin
    int n, ov0;
    logic [127:0] kexp;
    rst_n = 1'b0; rst_nb = 1'b0;
    start_a = 0; abort_a = 0; puf_valid_a = 0; cfg_valid_a = 0; puf_a = '0; cfg_data_a = '0;
    start_b = 0; abort_b = 0; puf_valid_b = 0; cfg_valid_b = 0; puf_b = '0; cfg_data_b = '0;
    ifa.out_ready = 1'b0;
    #2;
    chk("reset_ctrl", 128'({busy_a, done_a, error_a, cfg_ready_a, ifa.out_valid, ifa.enc_start}), '0);
    chk("reset_enc", ifa.enc_key | ifa.enc_nonce | ifa.enc_plain, '0);
    chk("reset_out", ifa.out_ct | ifa.out_tag | 128'(ifa.out_idx), '0);
    #10;
    rst_n = 1'b1; rst_nb = 1'b1;
    tick();

    // Nominal table: fixed words and the known folded key.
    for (int j = 0; j < 8; j++) words[j] = 128'(16'h1111 * (j + 1));
    for (int i = 0; i < 4; i++) begin
      vt[i].plain     = {32'hC0DE0000 + i, 96'h0123456789ABCDEF00112233};
      vt[i].lat       = 5;
      vt[i].bp        = (i == 1) ? 7 : 0;
      vt[i].exp_nonce = 128'h10 + 128'(i);
      vt[i].exp_idx   = i;
    end
    gaps = 1'b0;
    run_a(128'h11112222333344445555666677778888);

    // Randomized runs against the fold reference.
    gaps = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 8; j++) words[j] = 128'(16'($urandom));
      for (int i = 0; i < 4; i++) begin
        vt[i].plain = {$urandom, $urandom, $urandom, $urandom};
        vt[i].lat   = $urandom_range(2, 8);
        vt[i].bp    = $urandom_range(0, 3);
      end
      run_a(fold_ref(8, 16));
    end
    gaps = 1'b0;

    // Timeout: core never answers.
    core_lat = 0;
    start_a_pulse();
    feed_a(8);
    chk1("to_cfg_ready", cfg_ready_a, 1'b1);
    cfg_valid_a = 1'b1;
    tick();
    cfg_valid_a = 1'b0;
    chk1("to_enc_start", ifa.enc_start, 1'b1);
    repeat (15) tick();
    chk1("to_error_early", error_a, 1'b0);
    tick();
    chk1("to_error", error_a, 1'b1);
    chk1("to_busy", busy_a, 1'b0);
    chk("to_enc_key", ifa.enc_key, '0);
    chk("to_key_zero", dut_a.u_fold.key_o, '0);
    repeat (3) tick();
    chk1("to_sticky", error_a, 1'b1);
    start_a_pulse();
    chk1("to_start_clears", error_a, 1'b0);
    chk1("to_restart_busy", busy_a, 1'b1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk1("abort_in_key", busy_a, 1'b0);

    // Abort coincident with enc_done in WAIT.
    core_lat = 4;
    ov0 = ov_cnt;
    start_a_pulse();
    feed_a(8);
    cfg_valid_a = 1'b1;
    tick();
    cfg_valid_a = 1'b0;
    n = 0;
    while (!ifa.enc_done && n < 50) begin tick(); n++; end
    chk1("ab_done_seen", ifa.enc_done, 1'b1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("ab_ctrl", 128'({busy_a, ifa.out_valid, done_a, error_a}), '0);
    chk("ab_enc_key", ifa.enc_key, '0);
    repeat (3) tick();
    chk("ab_no_out", 128'(ov_cnt), 128'(ov0));

    // Odd width: 24-bit words, KEY_WORDS=6.
    for (int j = 0; j < 6; j++) words[j] = 128'(24'($urandom));
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int j = 0; j < 6; j++) begin
      puf_b = words[j][23:0];
      puf_valid_b = 1'b1;
      tick();
    end
    puf_valid_b = 1'b0;
    chk1("b_cfg_ready", cfg_ready_b, 1'b1);
    cfg_data_b = {$urandom, $urandom, $urandom, $urandom};
    cfg_valid_b = 1'b1;
    tick();
    cfg_valid_b = 1'b0;
    chk1("b_enc_start", ifb.enc_start, 1'b1);
    chk("b_enc_key", ifb.enc_key, fold_ref(6, 24));
    chk("b_enc_nonce", ifb.enc_nonce, '0);
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    chk1("b_abort_idle", busy_b, 1'b0);

    // Asynchronous reset in the middle of key folding.
    for (int j = 0; j < 3; j++) words[j] = 128'(24'($urandom) | 24'h1);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int j = 0; j < 3; j++) begin
      puf_b = words[j][23:0];
      puf_valid_b = 1'b1;
      tick();
    end
    puf_valid_b = 1'b0;
    chk1("b_busy_mid_key", busy_b, 1'b1);
    chk("b_partial_key", dut_b.u_fold.key_o, fold_ref(3, 24));
    #3;
    rst_nb = 1'b0;
    #1;
    chk("b_rst_ctrl", 128'({busy_b, done_b, error_b, cfg_ready_b, ifb.out_valid, ifb.enc_start}), '0);
    chk("b_rst_key", dut_b.u_fold.key_o | ifb.enc_key, '0);
    #1;
    rst_nb = 1'b1;
    tick();
    chk1("b_idle_after_rst", busy_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
